// File: rtl/light_fsm.sv
// light_fsm: traffic-light sequencer that feeds the seconds timer and drives registered lamps.
// Define LIGHT_PED_REQ_EN to build the pedestrian request latch and the GREEN early-exit rule.
module light_fsm #(
  parameter int unsigned DUR_RED        = 5,
  parameter int unsigned DUR_RY         = 1,
  parameter int unsigned DUR_GREEN      = 6,
  parameter int unsigned GREEN_MIN      = 2,
  parameter int unsigned DUR_YEL        = 2,
  parameter int unsigned STATE_SIZE     = 2,
  parameter int unsigned SEC_TIMER_SIZE = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    service,
  input  logic                    ped_req,
  input  logic [SEC_TIMER_SIZE:0] sec_t,
  output logic [STATE_SIZE:0]     state_next,
  output logic [STATE_SIZE:0]     state_reg,
  output logic                    lamp_r,
  output logic                    lamp_y,
  output logic                    lamp_g,
  output logic                    ped_pending
);

  localparam int unsigned SW = STATE_SIZE + 1;
  localparam int unsigned TW = SEC_TIMER_SIZE + 1;

  localparam logic [TW-1:0] DUR_RED_T   = TW'(DUR_RED);
  localparam logic [TW-1:0] DUR_RY_T    = TW'(DUR_RY);
  localparam logic [TW-1:0] DUR_GREEN_T = TW'(DUR_GREEN);
  localparam logic [TW-1:0] GREEN_MIN_T = TW'(GREEN_MIN);
  localparam logic [TW-1:0] DUR_YEL_T   = TW'(DUR_YEL);

  typedef enum logic [SW-1:0] {
    IDLE    = SW'(0),
    RED     = SW'(1),
    RED_YEL = SW'(2),
    GREEN   = SW'(3),
    YEL     = SW'(4),
    BLINK   = SW'(5)
  } state_e;

  logic [SW-1:0] state_q;
  state_e        state_d;

  logic start_q;
  logic armed_q;
  logic start_edge;
  logic state_legal;
  logic entering;
  logic green_done;
  logic ped_q;

  logic lamp_r_q, lamp_y_q, lamp_g_q;
  logic lamp_r_d, lamp_y_d, lamp_g_d;

  // armed_q masks the first edge after reset so a start held high through release is not an edge.
  assign start_edge  = armed_q & start & ~start_q;
  assign state_legal = (state_q <= BLINK);
  assign entering    = (state_q != state_d);
  assign green_done  = (sec_t == DUR_GREEN_T) || (ped_q && (sec_t >= GREEN_MIN_T));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = IDLE;
    if (!state_legal || stop) begin
      state_d = IDLE;
    end else if (service) begin
      state_d = BLINK;
    end else begin
      case (state_q)
        BLINK:   state_d = RED;
        IDLE: begin
          if (start_edge) state_d = RED;
          else            state_d = IDLE;
        end
        RED: begin
          if (sec_t == DUR_RED_T) state_d = RED_YEL;
          else                    state_d = RED;
        end
        RED_YEL: begin
          if (sec_t == DUR_RY_T) state_d = GREEN;
          else                   state_d = RED_YEL;
        end
        GREEN: begin
          if (green_done) state_d = YEL;
          else            state_d = GREEN;
        end
        YEL: begin
          if (sec_t == DUR_YEL_T) state_d = RED;
          else                    state_d = YEL;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Lamps decode the next state so they land on the same edge as state_reg. In BLINK the
  // yellow follows the seconds count the timer holds after this edge, which is 0 on entry.
  always_comb begin
    lamp_r_d = 1'b0;
    lamp_y_d = 1'b0;
    lamp_g_d = 1'b0;
    case (state_d)
      RED:     lamp_r_d = 1'b1;
      RED_YEL: begin
        lamp_r_d = 1'b1;
        lamp_y_d = 1'b1;
      end
      GREEN:   lamp_g_d = 1'b1;
      YEL:     lamp_y_d = 1'b1;
      BLINK:   lamp_y_d = entering ? 1'b1 : ~sec_t[0];
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
      lamp_r_q <= 1'b0;
      lamp_y_q <= 1'b0;
      lamp_g_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      armed_q  <= 1'b1;
      lamp_r_q <= lamp_r_d;
      lamp_y_q <= lamp_y_d;
      lamp_g_q <= lamp_g_d;
    end
  end

`ifdef LIGHT_PED_REQ_EN
  logic ped_d;

  // A new request wins over the clear that happens on entry to RED, IDLE or BLINK.
  always_comb begin
    ped_d = ped_q;
    if (entering && (state_d == IDLE || state_d == RED || state_d == BLINK)) ped_d = 1'b0;
    if (ped_req) ped_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ped_q <= 1'b0;
    else        ped_q <= ped_d;
  end
`else
  logic ped_req_unused;

  assign ped_req_unused = ped_req;
  assign ped_q          = 1'b0;
`endif

  assign state_next  = state_d;
  assign state_reg   = state_q;
  assign lamp_r      = lamp_r_q;
  assign lamp_y      = lamp_y_q;
  assign lamp_g      = lamp_g_q;
  assign ped_pending = ped_q;

endmodule
